multi_mode_timer: RTL and testbench

//  Parametrised single-channel timer/counter; successor to the plain free-running enable counter.

---
 rtl/multi_mode_timer.sv | 180 ++++++++++++++++++
 tb/tb_multi_mode_timer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/multi_mode_timer.sv
// Single-channel timer/counter with a prescaler, four counting modes, preload,
// synchronised input capture and sticky overflow/capture flags.
module multi_mode_timer #(
  parameter int DATA_WIDTH     = 16,
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic                      CLOCK,
  input  logic                      RESET,
  input  logic                      ENABLE,
  input  logic [1:0]                MODE,
  input  logic [DATA_WIDTH-1:0]     PERIOD,
  input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
  input  logic                      LOAD_STROBE,
  input  logic [DATA_WIDTH-1:0]     LOAD_VALUE,
  input  logic                      CAPTURE_IN,
  input  logic                      CLEAR_FLAGS,
  output logic [DATA_WIDTH-1:0]     DATA,
  output logic [DATA_WIDTH-1:0]     CAPTURE_DATA,
  output logic                      TERMINAL,
  output logic                      OVERFLOW_FLAG,
  output logic                      CAPTURE_FLAG,
  output logic                      RUNNING
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [1:0] MODE_FREE    = 2'b00;
  localparam logic [1:0] MODE_PERIOD  = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;
  localparam logic [1:0] MODE_DOWN    = 2'b11;

  localparam logic [DATA_WIDTH-1:0]     CNT_ONE   = 1;
  localparam logic [DATA_WIDTH-1:0]     CNT_MAX   = '1;
  localparam logic [PRESCALE_WIDTH-1:0] PRESC_ONE = 1;

  state_t                    state_q, state_d;
  logic [1:0]                mode_q, mode_d;
  logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;
  logic [DATA_WIDTH-1:0]     count_q, count_d;
  logic [DATA_WIDTH-1:0]     cap_data_q, cap_data_d;
  logic                      terminal_q, terminal_d;
  logic                      ovf_q, ovf_d;
  logic                      cap_flag_q, cap_flag_d;
  logic                      sync1_q, sync1_d;
  logic                      sync2_q, sync2_d;
  logic                      edge_q, edge_d;
  logic                      tick;
  logic                      cap_detect;
  logic [DATA_WIDTH-1:0]     count_up;

  assign count_up   = count_q + CNT_ONE;
  assign cap_detect = sync2_q & ~edge_q;

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    presc_d    = presc_q;
    count_d    = count_q;
    cap_data_d = cap_data_q;
    terminal_d = 1'b0;
    ovf_d      = ovf_q;
    cap_flag_d = cap_flag_q;
    sync1_d    = CAPTURE_IN;
    sync2_d    = sync1_q;
    edge_d     = sync2_q;
    tick       = 1'b0;

    if (state_q == IDLE && ENABLE) begin
      state_d = RUN;
      mode_d  = MODE;
    end

    if (state_q == RUN && ENABLE) begin
      if (presc_q == PRESCALE) begin
        tick    = 1'b1;
        presc_d = '0;
      end else begin
        presc_d = presc_q + PRESC_ONE;
      end
    end

    if (tick) begin
      case (mode_q)
        MODE_FREE: begin
          count_d    = count_up;
          terminal_d = (count_q == CNT_MAX);
        end
        MODE_PERIOD: begin
          if (count_q == PERIOD) begin
            count_d    = '0;
            terminal_d = 1'b1;
          end else begin
            count_d = count_up;
          end
        end
        MODE_ONESHOT: begin
          count_d = count_up;
          if (count_up == PERIOD) begin
            terminal_d = 1'b1;
            state_d    = DONE;
          end
        end
        MODE_DOWN: begin
          if (count_q == '0) begin
            count_d    = PERIOD;
            terminal_d = 1'b1;
          end else begin
            count_d = count_q - CNT_ONE;
          end
        end
        default: count_d = count_q;
      endcase
    end

    // A preload wins over any tick in the same cycle, including a one-shot finish.
    if (LOAD_STROBE) begin
      count_d    = LOAD_VALUE;
      presc_d    = '0;
      terminal_d = 1'b0;
      mode_d     = MODE;
      if (state_q != IDLE) begin
        state_d = RUN;
      end
    end

    if (terminal_d) begin
      ovf_d = 1'b1;
    end else if (CLEAR_FLAGS) begin
      ovf_d = 1'b0;
    end

    // Capture the count as it appears after this edge, so it matches DATA.
    if (cap_detect) begin
      cap_data_d = count_d;
      cap_flag_d = 1'b1;
    end else if (CLEAR_FLAGS) begin
      cap_flag_d = 1'b0;
    end
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q    <= IDLE;
      mode_q     <= MODE_FREE;
      presc_q    <= '0;
      count_q    <= '0;
      cap_data_q <= '0;
      terminal_q <= 1'b0;
      ovf_q      <= 1'b0;
      cap_flag_q <= 1'b0;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      edge_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      presc_q    <= presc_d;
      count_q    <= count_d;
      cap_data_q <= cap_data_d;
      terminal_q <= terminal_d;
      ovf_q      <= ovf_d;
      cap_flag_q <= cap_flag_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      edge_q     <= edge_d;
    end
  end

  assign DATA          = count_q;
  assign CAPTURE_DATA  = cap_data_q;
  assign TERMINAL      = terminal_q;
  assign OVERFLOW_FLAG = ovf_q;
  assign CAPTURE_FLAG  = cap_flag_q;
  assign RUNNING       = (state_q == RUN) && ENABLE;

endmodule

// File: tb/tb_multi_mode_timer.sv
// Directed-vector bench for multi_mode_timer: a per-cycle vector table for the
// counting modes, then hand-written capture, pause and reset sequences.
module tb_multi_mode_timer;

  logic        clock;
  logic        reset;
  logic        enable;
  logic [1:0]  mode;
  logic [15:0] period;
  logic [7:0]  prescale;
  logic        load_strobe;
  logic [15:0] load_value;
  logic        capture_in;
  logic        clear_flags;
  logic [15:0] data;
  logic [15:0] capture_data;
  logic        terminal;
  logic        overflow_flag;
  logic        capture_flag;
  logic        running;

  int n_vectors     = 0;
  int n_miscompares = 0;

  typedef struct {
    logic        en;
    logic [1:0]  mode;
    logic [15:0] period;
    logic [7:0]  presc;
    logic        load;
    logic [15:0] lv;
    logic        clr;
    logic [15:0] e_data;
    logic        e_term;
    logic        e_ovf;
    logic        e_run;
  } vec_t;

  vec_t vecs[$];

  multi_mode_timer #(.DATA_WIDTH(16), .PRESCALE_WIDTH(8)) dut (
    .CLOCK        (clock),
    .RESET        (reset),
    .ENABLE       (enable),
    .MODE         (mode),
    .PERIOD       (period),
    .PRESCALE     (prescale),
    .LOAD_STROBE  (load_strobe),
    .LOAD_VALUE   (load_value),
    .CAPTURE_IN   (capture_in),
    .CLEAR_FLAGS  (clear_flags),
    .DATA         (data),
    .CAPTURE_DATA (capture_data),
    .TERMINAL     (terminal),
    .OVERFLOW_FLAG(overflow_flag),
    .CAPTURE_FLAG (capture_flag),
    .RUNNING      (running)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic void add_vec(input logic en, input logic [1:0] md, input logic [15:0] per,
                                  input logic [7:0] ps, input logic ld, input logic [15:0] lv,
                                  input logic clr, input logic [15:0] ed, input logic et,
                                  input logic eo, input logic er);
    vecs.push_back('{en, md, per, ps, ld, lv, clr, ed, et, eo, er});
  endfunction

  task automatic apply_stimulus(input vec_t v);
    enable      = v.en;
    mode        = v.mode;
    period      = v.period;
    prescale    = v.presc;
    load_strobe = v.load;
    load_value  = v.lv;
    clear_flags = v.clr;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    // en mode period presc load lv clr | data term ovf run
    add_vec(0, 2'b00, 16'd0, 8'd0, 1, 16'hFFFE, 0, 16'hFFFE, 0, 0, 0);
    add_vec(1, 2'b00, 16'd0, 8'd0, 0, 16'h0000, 0, 16'hFFFE, 0, 0, 1);
    add_vec(1, 2'b00, 16'd0, 8'd0, 0, 16'h0000, 0, 16'hFFFF, 0, 0, 1);
    add_vec(1, 2'b00, 16'd0, 8'd0, 0, 16'h0000, 0, 16'h0000, 1, 1, 1);
    add_vec(1, 2'b00, 16'd0, 8'd0, 0, 16'h0000, 0, 16'h0001, 0, 1, 1);
    add_vec(0, 2'b00, 16'd0, 8'd0, 0, 16'h0000, 1, 16'h0001, 0, 0, 0);
    // periodic-up, PERIOD=4, PRESCALE=2: one step every three enabled cycles
    add_vec(0, 2'b01, 16'd4, 8'd2, 1, 16'h0000, 0, 16'h0000, 0, 0, 0);
    for (int i = 0; i < 15; i++) begin
      logic [15:0] d;
      d = 16'((i + 1) / 3);
      if (i == 14) add_vec(1, 2'b01, 16'd4, 8'd2, 0, 16'h0, 0, 16'h0000, 1, 1, 1);
      else         add_vec(1, 2'b01, 16'd4, 8'd2, 0, 16'h0, 0, d, 0, 0, 1);
    end
    // one-shot, PERIOD=3, then restart by preload from DONE
    add_vec(0, 2'b10, 16'd3, 8'd0, 1, 16'h0000, 1, 16'h0000, 0, 0, 0);
    add_vec(1, 2'b10, 16'd3, 8'd0, 0, 16'h0000, 0, 16'h0001, 0, 0, 1);
    add_vec(1, 2'b10, 16'd3, 8'd0, 0, 16'h0000, 0, 16'h0002, 0, 0, 1);
    add_vec(1, 2'b10, 16'd3, 8'd0, 0, 16'h0000, 0, 16'h0003, 1, 1, 0);
    add_vec(1, 2'b10, 16'd3, 8'd0, 0, 16'h0000, 0, 16'h0003, 0, 1, 0);
    add_vec(1, 2'b10, 16'd3, 8'd0, 1, 16'h0000, 0, 16'h0000, 0, 1, 1);
    add_vec(1, 2'b10, 16'd3, 8'd0, 0, 16'h0000, 0, 16'h0001, 0, 1, 1);
    // periodic-down, PERIOD=2; clear collides with terminal on the reload
    add_vec(0, 2'b11, 16'd2, 8'd0, 1, 16'h0002, 1, 16'h0002, 0, 0, 0);
    add_vec(1, 2'b11, 16'd2, 8'd0, 0, 16'h0000, 0, 16'h0001, 0, 0, 1);
    add_vec(1, 2'b11, 16'd2, 8'd0, 0, 16'h0000, 0, 16'h0000, 0, 0, 1);
    add_vec(1, 2'b11, 16'd2, 8'd0, 0, 16'h0000, 1, 16'h0002, 1, 1, 1);
    add_vec(1, 2'b11, 16'd2, 8'd0, 0, 16'h0000, 0, 16'h0001, 0, 1, 1);
    add_vec(0, 2'b11, 16'd2, 8'd0, 0, 16'h0000, 0, 16'h0001, 0, 1, 0);
    // periodic-up with PERIOD=0; a MODE change without preload is ignored
    add_vec(0, 2'b01, 16'd0, 8'd0, 1, 16'h0000, 0, 16'h0000, 0, 1, 0);
    add_vec(1, 2'b01, 16'd0, 8'd0, 0, 16'h0000, 0, 16'h0000, 1, 1, 1);
    add_vec(1, 2'b01, 16'd0, 8'd0, 0, 16'h0000, 0, 16'h0000, 1, 1, 1);
    add_vec(1, 2'b00, 16'd0, 8'd0, 0, 16'h0000, 0, 16'h0000, 1, 1, 1);

    reset       = 1'b1;
    enable      = 1'b0;
    mode        = 2'b00;
    period      = '0;
    prescale    = '0;
    load_strobe = 1'b0;
    load_value  = '0;
    capture_in  = 1'b0;
    clear_flags = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    n_vectors++;
    check_output("reset data", data, 16'h0);
    check_output("reset capture_data", capture_data, 16'h0);
    check_output("reset terminal", terminal, 1'b0);
    check_output("reset overflow", overflow_flag, 1'b0);
    check_output("reset capture_flag", capture_flag, 1'b0);
    check_output("reset running", running, 1'b0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i]);
      step();
      n_vectors++;
      check_output($sformatf("v%0d data", i), data, vecs[i].e_data);
      check_output($sformatf("v%0d terminal", i), terminal, vecs[i].e_term);
      check_output($sformatf("v%0d overflow", i), overflow_flag, vecs[i].e_ovf);
      check_output($sformatf("v%0d running", i), running, vecs[i].e_run);
    end

    // Capture: input rises while DATA=0x0010, detected on the third edge.
    load_strobe = 1'b1; load_value = 16'h000F; mode = 2'b00; enable = 1'b0;
    prescale = 8'd0; clear_flags = 1'b1;
    step();
    load_strobe = 1'b0; clear_flags = 1'b0; enable = 1'b1;
    step();
    n_vectors++;
    check_output("cap start data", data, 16'h0010);
    capture_in = 1'b1;
    step();
    step();
    n_vectors++;
    check_output("cap early flag", capture_flag, 1'b0);
    step();
    n_vectors++;
    check_output("cap data", capture_data, 16'h0013);
    check_output("cap flag", capture_flag, 1'b1);
    check_output("cap run data", data, 16'h0013);
    clear_flags = 1'b1;
    step();
    clear_flags = 1'b0;
    n_vectors++;
    check_output("cap clear flag", capture_flag, 1'b0);
    check_output("cap held data", capture_data, 16'h0013);
    check_output("cap count", data, 16'h0014);

    // Pause with ENABLE low, then resume.
    enable = 1'b0;
    step();
    step();
    n_vectors++;
    check_output("pause data", data, 16'h0014);
    check_output("pause running", running, 1'b0);
    enable = 1'b1;
    step();
    n_vectors++;
    check_output("resume data", data, 16'h0015);
    check_output("resume running", running, 1'b1);

    // Asynchronous reset in the middle of a clock period.
    capture_in = 1'b0;
    step();
    #2;
    reset = 1'b1;
    #1;
    n_vectors++;
    check_output("async data", data, 16'h0);
    check_output("async capture_data", capture_data, 16'h0);
    check_output("async capture_flag", capture_flag, 1'b0);
    check_output("async terminal", terminal, 1'b0);
    check_output("async running", running, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    step();
    step();
    n_vectors++;
    check_output("post-reset data", data, 16'h0001);
    check_output("post-reset running", running, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
